// File: rtl/divide_unit.sv
// Iterative 32-bit restoring divider with a 33-cycle start-to-done latency.
// Signed (RV32M DIV/REM) support is compiled in only when DIVIDE_UNIT_SIGNED_EN is defined.
module divide_unit #(
  parameter int XLEN = 32
) (
  input  logic            clock,
  input  logic            reset,
  input  logic            start,
  input  logic            op_signed,
  input  logic [XLEN-1:0] dividend,
  input  logic [XLEN-1:0] divisor,
  output logic            busy,
  output logic            done,
  output logic [XLEN-1:0] quotient,
  output logic [XLEN-1:0] remainder,
  output logic            div_by_zero
);

  typedef enum logic [1:0] {IDLE, CALC, DONE} state_t;

  state_t          state_q, state_d;
  logic [5:0]      cnt_q, cnt_d;
  logic            busy_q, busy_d;
  logic            done_q, done_d;
  logic [XLEN-1:0] quotient_q, quotient_d;
  logic [XLEN-1:0] remainder_q, remainder_d;
  logic            div_by_zero_q, div_by_zero_d;

  // Working registers: partial remainder, dividend/quotient shifter, divisor.
  logic [XLEN-1:0] acc_q, acc_d;
  logic [XLEN-1:0] quo_q, quo_d;
  logic [XLEN-1:0] dvs_q, dvs_d;
  logic            dbz_q, dbz_d;

  logic [XLEN-1:0] dvd_mag, dvs_mag;
  logic [XLEN:0]   shifted;
  logic [XLEN-1:0] trial;
  logic            step_bit;
  logic [XLEN-1:0] step_acc;

`ifdef DIVIDE_UNIT_SIGNED_EN
  logic neg_quo_q, neg_quo_d;
  logic neg_rem_q, neg_rem_d;
  logic sign_a, sign_b;

  function automatic logic [XLEN-1:0] twos_neg(input logic [XLEN-1:0] v);
    return ~v + 1'b1;
  endfunction

  always_comb begin
    sign_a  = op_signed & dividend[XLEN-1];
    sign_b  = op_signed & divisor[XLEN-1];
    dvd_mag = sign_a ? twos_neg(dividend) : dividend;
    dvs_mag = sign_b ? twos_neg(divisor) : divisor;
  end
`else
  logic op_signed_unused;
  assign op_signed_unused = op_signed;
  assign dvd_mag = dividend;
  assign dvs_mag = divisor;
`endif

  // One restoring step: shift in the next dividend bit, subtract if it fits.
  always_comb begin
    shifted  = {acc_q, quo_q[XLEN-1]};
    step_bit = (shifted >= {1'b0, dvs_q});
    trial    = shifted[XLEN-1:0] - dvs_q;
    step_acc = step_bit ? trial : shifted[XLEN-1:0];
  end

  always_comb begin
    state_d       = state_q;
    cnt_d         = cnt_q;
    acc_d         = acc_q;
    quo_d         = quo_q;
    dvs_d         = dvs_q;
    dbz_d         = dbz_q;
    done_d        = 1'b0;
    quotient_d    = quotient_q;
    remainder_d   = remainder_q;
    div_by_zero_d = div_by_zero_q;
`ifdef DIVIDE_UNIT_SIGNED_EN
    neg_quo_d     = neg_quo_q;
    neg_rem_d     = neg_rem_q;
`endif
    case (state_q)
      IDLE, DONE: begin
        if (start) begin
          state_d = CALC;
          cnt_d   = 6'd32;
          acc_d   = '0;
          quo_d   = dvd_mag;
          dvs_d   = dvs_mag;
          dbz_d   = (divisor == '0);
`ifdef DIVIDE_UNIT_SIGNED_EN
          neg_quo_d = sign_a ^ sign_b;
          neg_rem_d = sign_a;
`endif
        end else begin
          state_d = IDLE;
        end
      end
      CALC: begin
        if (cnt_q != 6'd0) begin
          acc_d = step_acc;
          quo_d = {quo_q[XLEN-2:0], step_bit};
          cnt_d = cnt_q - 6'd1;
        end else begin
          // Final edge: apply sign fix-up and publish the result.
          state_d       = DONE;
          done_d        = 1'b1;
          div_by_zero_d = dbz_q;
`ifdef DIVIDE_UNIT_SIGNED_EN
          quotient_d    = dbz_q ? '1 : (neg_quo_q ? twos_neg(quo_q) : quo_q);
          remainder_d   = neg_rem_q ? twos_neg(acc_q) : acc_q;
`else
          quotient_d    = quo_q;
          remainder_d   = acc_q;
`endif
        end
      end
      default: state_d = IDLE;
    endcase
    busy_d = (state_q == CALC) && (state_d == CALC);
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state_q       <= IDLE;
      cnt_q         <= '0;
      busy_q        <= 1'b0;
      done_q        <= 1'b0;
      quotient_q    <= '0;
      remainder_q   <= '0;
      div_by_zero_q <= 1'b0;
    end else begin
      state_q       <= state_d;
      cnt_q         <= cnt_d;
      busy_q        <= busy_d;
      done_q        <= done_d;
      quotient_q    <= quotient_d;
      remainder_q   <= remainder_d;
      div_by_zero_q <= div_by_zero_d;
    end
  end

  always_ff @(posedge clock) begin
    acc_q <= acc_d;
    quo_q <= quo_d;
    dvs_q <= dvs_d;
    dbz_q <= dbz_d;
`ifdef DIVIDE_UNIT_SIGNED_EN
    neg_quo_q <= neg_quo_d;
    neg_rem_q <= neg_rem_d;
`endif
  end

  assign busy        = busy_q;
  assign done        = done_q;
  assign quotient    = quotient_q;
  assign remainder   = remainder_q;
  assign div_by_zero = div_by_zero_q;

endmodule

// File: tb/tb_divide_unit.sv
// Directed bench for divide_unit: vector table plus back-to-back and reset-abort sequences.
module tb_divide_unit;

  logic        clock = 1'b0;
  logic        reset;
  logic        start;
  logic        op_signed;
  logic [31:0] dividend;
  logic [31:0] divisor;
  logic        busy;
  logic        done;
  logic [31:0] quotient;
  logic [31:0] remainder;
  logic        div_by_zero;

  int checks = 0;
  int errors = 0;

  divide_unit #(.XLEN(32)) dut (
    .clock(clock), .reset(reset), .start(start), .op_signed(op_signed),
    .dividend(dividend), .divisor(divisor), .busy(busy), .done(done),
    .quotient(quotient), .remainder(remainder), .div_by_zero(div_by_zero)
  );

  always #5 clock = ~clock;

  typedef struct {
    string       name;
    logic        sgn;
    logic [31:0] a;
    logic [31:0] b;
    logic [31:0] eq;
    logic [31:0] er;
    logic        edbz;
  } vec_t;

  vec_t vecs[10];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  // Issue one divide (caller is 1ns after a rising edge) and check latency and result.
  task automatic run_div(input string name, input logic sgn, input logic [31:0] a,
                         input logic [31:0] b, input logic [31:0] eq,
                         input logic [31:0] er, input logic edbz);
    int n;
    op_signed = sgn;
    dividend  = a;
    divisor   = b;
    start     = 1'b1;
    tick();
    start    = 1'b0;
    dividend = ~a;
    divisor  = b + 32'd3;
    n = 0;
    while (n < 40) begin
      tick();
      n++;
      if (n == 1) chk({name, " busy_after_start"}, {31'd0, busy}, 32'd1);
      if (done) break;
    end
    chk({name, " latency"}, n, 32'd33);
    chk({name, " quotient"}, quotient, eq);
    chk({name, " remainder"}, remainder, er);
    chk({name, " div_by_zero"}, {31'd0, div_by_zero}, {31'd0, edbz});
    chk({name, " busy_in_done"}, {31'd0, busy}, 32'd0);
  endtask

  initial begin
    int n;
    int seen_done;

    vecs[0] = '{"u100_7",   1'b0, 32'd100,       32'd7,         32'd14,        32'd2,         1'b0};
    vecs[1] = '{"u12345_0", 1'b0, 32'd12345,     32'd0,         32'hFFFFFFFF,  32'd12345,     1'b1};
    vecs[2] = '{"umax_1",   1'b0, 32'hFFFFFFFF,  32'd1,         32'hFFFFFFFF,  32'd0,         1'b0};
    vecs[3] = '{"u5_10",    1'b0, 32'd5,         32'd10,        32'd0,         32'd5,         1'b0};
    vecs[4] = '{"udeadbeef",1'b0, 32'hDEADBEEF,  32'h10,        32'h0DEADBEE,  32'hF,         1'b0};
    vecs[5] = '{"sm7_0",    1'b1, 32'hFFFFFFF9,  32'd0,         32'hFFFFFFFF,  32'hFFFFFFF9,  1'b1};
`ifdef DIVIDE_UNIT_SIGNED_EN
    vecs[6] = '{"sm7_2",    1'b1, 32'hFFFFFFF9,  32'd2,         32'hFFFFFFFD,  32'hFFFFFFFF,  1'b0};
    vecs[7] = '{"s_ovf",    1'b1, 32'h80000000,  32'hFFFFFFFF,  32'h80000000,  32'd0,         1'b0};
    vecs[8] = '{"sm100_m7", 1'b1, 32'hFFFFFF9C,  32'hFFFFFFF9,  32'd14,        32'hFFFFFFFE,  1'b0};
    vecs[9] = '{"s100_m7",  1'b1, 32'd100,       32'hFFFFFFF9,  32'hFFFFFFF2,  32'd2,         1'b0};
`else
    vecs[6] = '{"sm7_2",    1'b1, 32'hFFFFFFF9,  32'd2,         32'h7FFFFFFC,  32'd1,         1'b0};
    vecs[7] = '{"s_ovf",    1'b1, 32'h80000000,  32'hFFFFFFFF,  32'd0,         32'h80000000,  1'b0};
    vecs[8] = '{"sm100_m7", 1'b1, 32'hFFFFFF9C,  32'hFFFFFFF9,  32'd0,         32'hFFFFFF9C,  1'b0};
    vecs[9] = '{"s100_m7",  1'b1, 32'd100,       32'hFFFFFFF9,  32'd0,         32'd100,       1'b0};
`endif

    reset = 1'b1;
    start = 1'b0;
    op_signed = 1'b0;
    dividend = '0;
    divisor = '0;
    tick();
    tick();
    chk("reset busy", {31'd0, busy}, 32'd0);
    chk("reset done", {31'd0, done}, 32'd0);
    chk("reset quotient", quotient, 32'd0);
    chk("reset remainder", remainder, 32'd0);
    chk("reset dbz", {31'd0, div_by_zero}, 32'd0);
    reset = 1'b0;
    tick();

    for (int i = 0; i < 10; i++) begin
      run_div(vecs[i].name, vecs[i].sgn, vecs[i].a, vecs[i].b,
              vecs[i].eq, vecs[i].er, vecs[i].edbz);
      tick();
      tick();
      chk({vecs[i].name, " hold_quotient"}, quotient, vecs[i].eq);
      chk({vecs[i].name, " done_single"}, {31'd0, done}, 32'd0);
    end

    // 10/10 with a 50/5 start pulse mid-calculation, which must be ignored.
    op_signed = 1'b0;
    dividend = 32'd10;
    divisor = 32'd10;
    start = 1'b1;
    tick();
    start = 1'b0;
    n = 0;
    while (n < 40) begin
      tick();
      n++;
      if (n == 5) begin
        dividend = 32'd50;
        divisor = 32'd5;
        start = 1'b1;
      end else if (n == 6) begin
        start = 1'b0;
      end
      if (done) break;
    end
    chk("b2b first latency", n, 32'd33);
    chk("b2b first quotient", quotient, 32'd1);
    chk("b2b first remainder", remainder, 32'd0);
    // Start issued in the DONE cycle: no bubble, exact latency again.
    run_div("b2b second", 1'b0, 32'd50, 32'd5, 32'd10, 32'd0, 1'b0);
    tick();

    // Reset asserted mid-calculation aborts with no done pulse.
    dividend = 32'd1000;
    divisor = 32'd3;
    start = 1'b1;
    tick();
    start = 1'b0;
    repeat (15) tick();
    chk("abort busy_before", {31'd0, busy}, 32'd1);
    reset = 1'b1;
    #1;
    chk("abort busy", {31'd0, busy}, 32'd0);
    chk("abort done", {31'd0, done}, 32'd0);
    chk("abort quotient", quotient, 32'd0);
    chk("abort remainder", remainder, 32'd0);
    chk("abort dbz", {31'd0, div_by_zero}, 32'd0);
    tick();
    reset = 1'b0;
    seen_done = 0;
    repeat (40) begin
      tick();
      if (done) seen_done++;
    end
    chk("abort no_done", seen_done, 32'd0);
    run_div("after_reset 9_3", 1'b0, 32'd9, 32'd3, 32'd3, 32'd0, 1'b0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
